sdf_stage_ctrl: RTL and testbench
=================================

# sdf_stage_ctrl

Parametrised control unit for one radix-2 single-path delay-feedback (SDF) FFT stage of length 2·HALF. It registers the incoming complex sample and drives the stage's mux-select state, output valid and twiddle factor W = exp(-j·2π·n/(2·HALF)) to the butterfly. It generalises the fixed 16-point stage controller in four ways:
- configurable depth and widths;
- gap-free back-to-back frames, with the drain of one frame overlapping the fill of the next;
- a per-frame inverse (IFFT) twiddle mode;
- framing-error detection.

## Interface
Parameters:
- HALF, 16: butterfly delay length (power of 2, ≥4); frame = 2·HALF samples.
- DW, 8: data width per real/imag component.
- TW, 8: twiddle width, signed fixed point (2 integer, TW-2 fractional bits).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- valid_i  in  1  input sample valid; a frame is 2·HALF consecutive valid cycles.
- inverse_i  in  1  conjugate twiddles for the frame; sampled at the frame's first sample.
- data_in_r / data_in_i  in  DW  signed input sample.
- valid_o  out  1  stage output valid.
- state  out  2  IDLE=00, FIRST=01 (sum path), SECOND=10 (difference drain), FILL=11.
- data_out_r / data_out_i  out  DW  data_in delayed one cycle (butterfly port A).
- wn_r / wn_i  out  TW  twiddle for the current SECOND cycle, 0 otherwise.
- err_o  out  1  one-cycle framing-error pulse.

## Operation
- **Sample alignment.** data_out is the registered data_in, updated every cycle regardless of valid_i. Frame sample n is presented at cycle c0+n and appears on data_out at cycle c0+1+n.
- **Counter.** cnt has width clog2(3·HALF) and indexes the stage phase. Phase ranges:
  - FILL: cnt 0..HALF-1.
  - FIRST: cnt HALF..2·HALF-1.
  - SECOND: cnt 2·HALF..3·HALF-1.
- **Back-to-back flag.** Register bb marks that the next frame started during SECOND.

State transitions:
- **IDLE**
  - valid_i=1 → FILL, cnt←0, latch inverse_i into inv_next.
- **FILL**
  - cnt++.
  - valid_i=0 → IDLE with err_o pulse.
  - cnt==HALF-1 with valid_i=1 → FIRST, valid_o←1.
- **FIRST**
  - cnt++.
  - valid_i=0 before cnt==2·HALF-1 → abort: IDLE, valid_o←0, err_o pulse.
  - On entry, inv_act←inv_next.
  - cnt==2·HALF-1 → SECOND. bb←valid_i; if valid_i=1, latch inverse_i into inv_next (next frame, sample 0).
- **SECOND**
  - cnt++.
  - If bb: valid_i must stay 1 every cycle. valid_i=0 → err_o pulse, bb←0, drain completes, then normal exit.
  - If !bb: valid_i=1 before the last cycle → err_o pulse; the sample is ignored.
  - Exit at cnt==3·HALF-1, in priority order:
    1. bb → FIRST, cnt←HALF (next frame's first half already filled).
    2. else valid_i → FILL, cnt←0, latch inverse_i.
    3. else → IDLE, valid_o←0.

Twiddles:
- Index k = cnt-2·HALF. wn = (C_re, C_im) = round(2^(TW-2)·cos(πk/HALF)), -round(2^(TW-2)·sin(πk/HALF)).
- Rounding is to nearest, ties away from zero.
- Quarter-wave ROM: Q[m] = round(2^(TW-2)·cos(πm/HALF)), m = 0..HALF/2, generated at elaboration.
  - k<HALF/2: re=Q[k], im=-Q[HALF/2-k].
  - k≥HALF/2: re=-Q[HALF-k], im=-Q[k-HALF/2].
- inv_act=1 negates wn_i. No overflow is possible, since |value| ≤ 2^(TW-2).
- wn is combinational from registered cnt/state/inv_act and is 0 outside SECOND.

## Timing
- **Reset** (asynchronous): state=00, cnt=0, bb=0, inv_act=inv_next=0.
  - Outputs: valid_o=0, err_o=0, data_out=0, wn=0.
  - Reset mid-frame discards everything. The first valid_i after release starts a fresh FILL.
- **Single frame**, first valid at cycle 0:
  - FILL cycles 1..HALF.
  - FIRST cycles HALF+1..2·HALF.
  - SECOND cycles 2·HALF+1..3·HALF.
  - IDLE at 3·HALF+1.
- valid_o is registered and high exactly during FIRST and SECOND.
- err_o is registered: it goes high the cycle after the offending valid_i sample and lasts one cycle.
- **Back-to-back:** valid_o stays continuously high and the state alternates FIRST/SECOND with no gap.

## Test plan
- **Reset:** assert rst_n=0 mid-SECOND → same cycle: state=00, valid_o=0, wn=0, data_out=0. Then 32 valid samples → normal frame.
- **Single frame** (HALF=16, TW=8), valid_i cycles 0-31:
  - state 11 at cycles 1-16, 01 at 17-32, 10 at 33-48, 00 at 49; valid_o high 17-48.
  - wn at cycle 33 = (64,0), 34 = (63,-12), 37 = (45,-45), 41 = (0,-64), 48 = (-63,-12).
  - data_out at cycle t = sample t-1.
- **Back-to-back:** valid_i continuous for cycles 0-63 → state 11×16, 01×16, 10×16, 01×16, 10×16, then 00 at 81; valid_o high 17-80 with no gap; err_o never asserted.
- **Inverse:**
  - Frame A with inverse_i=1 at cycle 0 → wn at 34 = (63,+12).
  - Frame B back-to-back with inverse_i=0 at cycle 32 → its SECOND wn at cycle 66 = (63,-12).
  - Toggling inverse_i mid-frame has no effect.
- **Framing error:** valid_i low at cycle 20 → cycle 21: err_o=1, state=00, valid_o=0; cycle 22: err_o=0.
- **Late start:** valid_i rises at cycle 40 during SECOND of a non-back-to-back frame → err_o=1 at cycle 41. Drain still completes to IDLE at 49, and wn keeps its sequence.

Source files
------------

// File: rtl/sdf_stage_ctrl.sv
// rtl/sdf_stage_ctrl.sv - control unit for one radix-2 single-path delay-feedback FFT stage
//
// Registers the incoming complex sample and sequences the stage through
// FILL -> FIRST -> SECOND. It supports gap-free back-to-back frames, a
// per-frame inverse (conjugate) twiddle mode and framing-error detection.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   valid_i                  input sample valid (frame = 2*HALF consecutive valids)
//   inverse_i                conjugate twiddles for the frame, sampled at sample 0
//   data_in_r / data_in_i    signed input sample
//   valid_o                  stage output valid (high during FIRST and SECOND)
//   state                    IDLE=00, FIRST=01, SECOND=10, FILL=11
//   data_out_r / data_out_i  data_in delayed one cycle (butterfly port A)
//   wn_r / wn_i              twiddle for the current SECOND cycle, 0 otherwise
//   err_o                    one-cycle framing-error pulse
module sdf_stage_ctrl #(
    parameter int HALF = 16,
    parameter int DW   = 8,
    parameter int TW   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_i,
    input  logic                 inverse_i,
    input  logic signed [DW-1:0] data_in_r,
    input  logic signed [DW-1:0] data_in_i,
    output logic                 valid_o,
    output logic [1:0]           state,
    output logic signed [DW-1:0] data_out_r,
    output logic signed [DW-1:0] data_out_i,
    output logic signed [TW-1:0] wn_r,
    output logic signed [TW-1:0] wn_i,
    output logic                 err_o
);
    localparam int CW = $clog2(3 * HALF);
    localparam int QW = $clog2(HALF / 2 + 1);

    localparam logic [CW-1:0] FILL_END   = CW'(HALF - 1);
    localparam logic [CW-1:0] FIRST_END  = CW'(2 * HALF - 1);
    localparam logic [CW-1:0] SECOND_END = CW'(3 * HALF - 1);

    // pi scaled by 2^28, used by the elaboration-time cosine below
    localparam longint PI_FX = 64'sd843314857;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_FIRST  = 2'b01,
        S_SECOND = 2'b10,
        S_FILL   = 2'b11
    } state_t;

    // round(2^(TW-2) * cos(pi*m/HALF)) for 0 <= m <= HALF/2, computed with a
    // fixed-point Taylor series so the ROM needs no real arithmetic.
    function automatic longint q_val(input int m);
        longint x, x2, term, sum, amp;
        x    = (PI_FX * longint'(m)) / longint'(HALF);
        x2   = (x * x) >>> 28;
        term = longint'(1) <<< 28;
        sum  = term;
        for (int i = 1; i <= 12; i++) begin
            term = -((term * x2) >>> 28) / longint'((2 * i - 1) * (2 * i));
            sum  = sum + term;
        end
        amp = longint'(1) <<< (TW - 2);
        return (amp * sum + (longint'(1) <<< 27)) >>> 28;
    endfunction

    logic signed [TW-1:0] qrom [HALF/2+1];

    for (genvar g = 0; g <= HALF / 2; g++) begin : g_qrom
        localparam logic signed [TW-1:0] QV = TW'(q_val(g));
        assign qrom[g] = QV;
    end

    state_t        st, st_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          bb, bb_nx;
    logic          inv_next, inv_next_nx;
    logic          inv_act, inv_act_nx;
    logic          err_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= S_IDLE;
            cnt        <= '0;
            bb         <= 1'b0;
            inv_next   <= 1'b0;
            inv_act    <= 1'b0;
            valid_o    <= 1'b0;
            err_o      <= 1'b0;
            data_out_r <= '0;
            data_out_i <= '0;
        end else begin
            st         <= st_nx;
            cnt        <= cnt_nx;
            bb         <= bb_nx;
            inv_next   <= inv_next_nx;
            inv_act    <= inv_act_nx;
            valid_o    <= (st_nx == S_FIRST) || (st_nx == S_SECOND);
            err_o      <= err_nx;
            data_out_r <= data_in_r;
            data_out_i <= data_in_i;
        end
    end

    always_comb begin
        st_nx       = st;
        cnt_nx      = cnt + CW'(1);
        bb_nx       = bb;
        inv_next_nx = inv_next;
        inv_act_nx  = inv_act;
        err_nx      = 1'b0;
        case (st)
            S_IDLE: begin
                cnt_nx = '0;
                if (valid_i) begin
                    st_nx       = S_FILL;
                    inv_next_nx = inverse_i;
                end
            end
            S_FILL: begin
                if (!valid_i) begin
                    st_nx  = S_IDLE;
                    cnt_nx = '0;
                    err_nx = 1'b1;
                end else if (cnt == FILL_END) begin
                    st_nx      = S_FIRST;
                    inv_act_nx = inv_next;
                end
            end
            S_FIRST: begin
                if (cnt == FIRST_END) begin
                    // the sample seen here is sample 0 of a possible next frame
                    st_nx = S_SECOND;
                    bb_nx = valid_i;
                    if (valid_i) begin
                        inv_next_nx = inverse_i;
                    end
                end else if (!valid_i) begin
                    st_nx  = S_IDLE;
                    cnt_nx = '0;
                    err_nx = 1'b1;
                end
            end
            S_SECOND: begin
                if (bb && !valid_i) begin
                    // overlapping frame broke; finish draining the current one
                    err_nx = 1'b1;
                    bb_nx  = 1'b0;
                end else if (!bb && valid_i && (cnt != SECOND_END)) begin
                    err_nx = 1'b1;
                end
                if (cnt == SECOND_END) begin
                    bb_nx = 1'b0;
                    if (bb && valid_i) begin
                        // next frame's first half is already in the delay line
                        st_nx      = S_FIRST;
                        cnt_nx     = CW'(HALF);
                        inv_act_nx = inv_next;
                    end else if (valid_i) begin
                        st_nx       = S_FILL;
                        cnt_nx      = '0;
                        inv_next_nx = inverse_i;
                    end else begin
                        st_nx  = S_IDLE;
                        cnt_nx = '0;
                    end
                end
            end
            default: begin
                st_nx  = S_IDLE;
                cnt_nx = '0;
            end
        endcase
    end

    assign state = st;

    // Quarter-wave lookup: k in [0, HALF) covers angles 0..pi.
    logic [CW-1:0]        k;
    logic signed [TW-1:0] tw_re, tw_im;

    always_comb begin
        k = cnt - CW'(2 * HALF);
        if (k < CW'(HALF / 2)) begin
            tw_re = qrom[QW'(k)];
            tw_im = -qrom[QW'(CW'(HALF / 2) - k)];
        end else begin
            tw_re = -qrom[QW'(CW'(HALF) - k)];
            tw_im = -qrom[QW'(k - CW'(HALF / 2))];
        end
        wn_r = '0;
        wn_i = '0;
        if (st == S_SECOND) begin
            wn_r = tw_re;
            wn_i = inv_act ? -tw_im : tw_im;
        end
    end

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// tb/tb_sdf_stage_ctrl.sv - scoreboard testbench for sdf_stage_ctrl
module tb_sdf_stage_ctrl;
    localparam int HALF = 16;
    localparam int DW   = 8;
    localparam int TW   = 8;
    localparam real MPI = 3.14159265358979323846;

    logic                 clk;
    logic                 rst_n;
    logic                 valid_i;
    logic                 inverse_i;
    logic signed [DW-1:0] data_in_r;
    logic signed [DW-1:0] data_in_i;
    logic                 valid_o;
    logic [1:0]           state;
    logic signed [DW-1:0] data_out_r;
    logic signed [DW-1:0] data_out_i;
    logic signed [TW-1:0] wn_r;
    logic signed [TW-1:0] wn_i;
    logic                 err_o;

    sdf_stage_ctrl #(.HALF(HALF), .DW(DW), .TW(TW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_i    (valid_i),
        .inverse_i  (inverse_i),
        .data_in_r  (data_in_r),
        .data_in_i  (data_in_i),
        .valid_o    (valid_o),
        .state      (state),
        .data_out_r (data_out_r),
        .data_out_i (data_out_i),
        .wn_r       (wn_r),
        .wn_i       (wn_i),
        .err_o      (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int st;
        int vo;
        int err;
        int dr;
        int di;
        int wr;
        int wi;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", nm, act, exp_v, $time);
        end
    endtask

    // Frame-age reference model: each frame is tracked by the number of
    // cycles since its sample 0; the stage phase follows from that age.
    bit m_on;
    int m_age;
    bit m_inv;
    bit n_on;
    bit n_inv;

    function automatic int rnd_away(input real r);
        if (r >= 0.0) return $rtoi(r + 0.5);
        return -$rtoi(-r + 0.5);
    endfunction

    task automatic model_reset();
        m_on  = 1'b0;
        m_age = 0;
        m_inv = 1'b0;
        n_on  = 1'b0;
        n_inv = 1'b0;
    endtask

    task automatic model_step(input bit v, input bit inv, input int dr, input int di);
        exp_t e;
        int   a;
        int   k;
        real  amp;
        bit   err;
        err = 1'b0;
        if (m_on) begin
            a = m_age;
            if (a < 2 * HALF) begin
                if (!v) begin
                    err  = 1'b1;
                    m_on = 1'b0;
                end
            end else if (a == 2 * HALF) begin
                n_on  = v;
                n_inv = inv;
            end else if (a < 3 * HALF) begin
                if (n_on && !v) begin
                    err  = 1'b1;
                    n_on = 1'b0;
                end else if (!n_on && v) begin
                    err = 1'b1;
                end
            end else begin
                if (n_on && v) begin
                    m_age = HALF;
                    m_inv = n_inv;
                end else if (n_on) begin
                    err  = 1'b1;
                    m_on = 1'b0;
                end else if (v) begin
                    m_age = 0;
                    m_inv = inv;
                end else begin
                    m_on = 1'b0;
                end
                n_on = 1'b0;
            end
        end else if (v) begin
            m_on  = 1'b1;
            m_age = 0;
            m_inv = inv;
        end
        m_age++;

        e.err = int'(err);
        e.dr  = dr;
        e.di  = di;
        e.wr  = 0;
        e.wi  = 0;
        if (!m_on)                 e.st = 0;
        else if (m_age <= HALF)    e.st = 3;
        else if (m_age <= 2*HALF)  e.st = 1;
        else                       e.st = 2;
        e.vo = (e.st == 1 || e.st == 2) ? 1 : 0;
        if (e.st == 2) begin
            k    = m_age - 2 * HALF - 1;
            amp  = 2.0 ** (TW - 2);
            e.wr = rnd_away(amp * $cos(MPI * k / HALF));
            e.wi = -rnd_away(amp * $sin(MPI * k / HALF));
            if (m_inv) e.wi = -e.wi;
        end
        exp_q.push_back(e);
    endtask

    task automatic step(input bit v, input bit inv);
        @(negedge clk);
        valid_i   = v;
        inverse_i = inv;
        data_in_r = DW'($urandom);
        data_in_i = DW'($urandom);
        model_step(v, inv, int'(data_in_r), int'(data_in_i));
        @(posedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("state",      int'(state),      mon_e.st);
            chk("valid_o",    int'(valid_o),    mon_e.vo);
            chk("err_o",      int'(err_o),      mon_e.err);
            chk("data_out_r", int'(data_out_r), mon_e.dr);
            chk("data_out_i", int'(data_out_i), mon_e.di);
            chk("wn_r",       int'(wn_r),       mon_e.wr);
            chk("wn_i",       int'(wn_i),       mon_e.wi);
        end
    end

    function automatic bit scn_valid(input int id, input int t);
        case (id)
            1:       return t < 32;
            2, 3:    return t < 64;
            4:       return t < 20;
            5:       return (t < 32) || (t == 40);
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit scn_inv(input int id, input int t);
        if (id != 3) return 1'b0;
        if (t == 0)  return 1'b1;
        if (t < 32)  return t[0];
        if (t == 32) return 1'b0;
        return t[1];
    endfunction

    task automatic run_scn(input int id, input int len);
        int c;
        for (int t = 0; t < len; t++) begin
            step(scn_valid(id, t), scn_inv(id, t));
            #2;
            c = t + 1;
            case (id)
                1: begin
                    if (c == 16) chk("s1_state_c16", int'(state), 3);
                    if (c == 17) chk("s1_state_c17", int'(state), 1);
                    if (c == 17) chk("s1_valid_c17", int'(valid_o), 1);
                    if (c == 33) chk("s1_state_c33", int'(state), 2);
                    if (c == 33) chk("s1_wn_r_c33", int'(wn_r), 64);
                    if (c == 33) chk("s1_wn_i_c33", int'(wn_i), 0);
                    if (c == 34) chk("s1_wn_r_c34", int'(wn_r), 63);
                    if (c == 34) chk("s1_wn_i_c34", int'(wn_i), -12);
                    if (c == 37) chk("s1_wn_r_c37", int'(wn_r), 45);
                    if (c == 37) chk("s1_wn_i_c37", int'(wn_i), -45);
                    if (c == 41) chk("s1_wn_r_c41", int'(wn_r), 0);
                    if (c == 41) chk("s1_wn_i_c41", int'(wn_i), -64);
                    if (c == 48) chk("s1_wn_r_c48", int'(wn_r), -63);
                    if (c == 48) chk("s1_wn_i_c48", int'(wn_i), -12);
                    if (c == 49) chk("s1_state_c49", int'(state), 0);
                    if (c == 49) chk("s1_valid_c49", int'(valid_o), 0);
                end
                2: begin
                    if (c == 49) chk("bb_state_c49", int'(state), 1);
                    if (c == 65) chk("bb_state_c65", int'(state), 2);
                    if (c == 80) chk("bb_valid_c80", int'(valid_o), 1);
                    if (c == 81) chk("bb_state_c81", int'(state), 0);
                end
                3: begin
                    if (c == 34) chk("inv_wn_i_c34", int'(wn_i), 12);
                    if (c == 34) chk("inv_wn_r_c34", int'(wn_r), 63);
                    if (c == 66) chk("inv_wn_i_c66", int'(wn_i), -12);
                end
                4: begin
                    if (c == 20) chk("ferr_state_c20", int'(state), 1);
                    if (c == 21) chk("ferr_err_c21", int'(err_o), 1);
                    if (c == 21) chk("ferr_state_c21", int'(state), 0);
                    if (c == 21) chk("ferr_valid_c21", int'(valid_o), 0);
                    if (c == 22) chk("ferr_err_c22", int'(err_o), 0);
                end
                5: begin
                    if (c == 41) chk("late_err_c41", int'(err_o), 1);
                    if (c == 41) chk("late_wn_i_c41", int'(wn_i), -64);
                    if (c == 42) chk("late_err_c42", int'(err_o), 0);
                    if (c == 49) chk("late_state_c49", int'(state), 0);
                end
                default: ;
            endcase
        end
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_state"},  int'(state),      0);
        chk({tag, "_valid"},  int'(valid_o),    0);
        chk({tag, "_err"},    int'(err_o),      0);
        chk({tag, "_wn_r"},   int'(wn_r),       0);
        chk({tag, "_wn_i"},   int'(wn_i),       0);
        chk({tag, "_dout_r"}, int'(data_out_r), 0);
        chk({tag, "_dout_i"}, int'(data_out_i), 0);
    endtask

    initial begin
        int len;
        int gap;
        rst_n     = 1'b0;
        valid_i   = 1'b0;
        inverse_i = 1'b0;
        data_in_r = '0;
        data_in_i = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset_checks("por");
        @(negedge clk);
        rst_n = 1'b1;

        run_scn(1, 55);
        run_scn(2, 88);
        run_scn(3, 88);
        run_scn(4, 30);
        run_scn(5, 55);

        // reset asserted in the middle of SECOND
        for (int t = 0; t < 38; t++) step(1'b1, 1'b0);
        @(negedge clk);
        rst_n   = 1'b0;
        valid_i = 1'b0;
        #1;
        reset_checks("midrst");
        model_reset();
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_scn(1, 55);

        for (int b = 0; b < 40; b++) begin
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 90))
                                              : 32 * int'($urandom_range(1, 3));
            gap = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 40));
            for (int i = 0; i < len; i++) step(1'b1, bit'($urandom_range(0, 1)));
            for (int i = 0; i < gap; i++)
                step($urandom_range(0, 19) == 0, bit'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 60; i++) step(1'b0, 1'b0);

        @(posedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
